// File: rtl/riscv_pc_fetch.sv
// Program counter and instruction-fetch sequencer: one instruction in flight,
// req/ack fetch, next-PC selection for branch/JAL/JALR, misalignment trap, retire counter.
module riscv_pc_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] link_o,
  input  logic        exec_done_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        alu_flag_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic        trap_o,
  output logic [31:0] bad_addr_o,
  output logic [31:0] instret_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] bad_addr_reg, bad_addr_next;
  logic [31:0] instret_reg, instret_next;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        retire;

  // Next-PC selection; JALR has highest priority and drops bit 0 of its sum.
  always_comb begin
    jalr_sum = rs1_i + imm_i;
    target   = pc_reg + 32'd4;
    if (jalr_i) begin
      target = jalr_sum & ~32'h1;
    end else if (jal_i || (branch_i && alu_flag_i)) begin
      target = pc_reg + imm_i;
    end
  end

  assign retire = (state_reg == HOLD) && exec_done_i && !stall_i;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    bad_addr_next = bad_addr_reg;
    instret_next  = instret_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ack_i) begin
          instr_next = imem_rdata_i;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          instret_next = instret_reg + 32'd1;
          // Without compressed instructions, bit 1 of a target must be clear.
          if (target[1]) begin
            bad_addr_next = target;
            state_next    = TRAP;
          end else begin
            pc_next    = target;
            state_next = REQ;
          end
        end
      end
      TRAP: state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_ADDR;
      instr_reg    <= NOP;
      bad_addr_reg <= 32'h0;
      instret_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      bad_addr_reg <= bad_addr_next;
      instret_reg  <= instret_next;
    end
  end

  assign imem_req_o    = (state_reg == REQ);
  assign imem_addr_o   = pc_reg;
  assign instr_o       = instr_reg;
  assign instr_valid_o = (state_reg == HOLD);
  assign pc_o          = pc_reg;
  assign link_o        = pc_reg + 32'd4;
  assign trap_o        = (state_reg == TRAP);
  assign bad_addr_o    = bad_addr_reg;
  assign instret_o     = instret_reg;

endmodule

// File: tb/tb_riscv_pc_fetch.sv
// Bench for riscv_pc_fetch: a phase-level reference model compared every cycle,
// plus directed jumps, branches, stalls, wrap-around, traps and reset pulses.
module tb_riscv_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'h1357_9BDF;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, link, bad_addr, instret;
  logic        instr_valid, trap;
  logic        exec_done, stall, branch, alu_flag, jal, jalr;
  logic [31:0] imm, rs1;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          req_cnt;
  logic [31:0] fetch_log[$];

  riscv_pc_fetch #(.RESET_ADDR(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc), .link_o(link),
    .exec_done_i(exec_done), .stall_i(stall), .branch_i(branch), .alu_flag_i(alu_flag),
    .jal_i(jal), .jalr_i(jalr), .imm_i(imm), .rs1_i(rs1),
    .trap_o(trap), .bad_addr_o(bad_addr), .instret_o(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: answers after ack_delay waiting cycles; data is a tag of the address.
  assign imem_ack   = ack_force || (imem_req && (req_cnt >= ack_delay));
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk or posedge rst) begin
    if (rst) req_cnt <= 0;
    else if (imem_req && !imem_ack) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  // Reference model: booting, fetching, executing or trapped.
  logic        m_boot, m_fetch, m_exec, m_trap;
  logic [31:0] m_pc, m_instr, m_bad, m_instret;

  function automatic logic [31:0] model_target(input logic [31:0] cur_pc);
    logic [31:0] s;
    s = rs1 + imm;
    if (jalr) return {s[31:1], 1'b0};
    if (jal) return cur_pc + imm;
    if (branch && alu_flag) return cur_pc + imm;
    return cur_pc + 32'd4;
  endfunction

  wire [31:0] m_target = model_target(m_pc);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot <= 1'b1; m_fetch <= 1'b0; m_exec <= 1'b0; m_trap <= 1'b0;
      m_pc <= RST_PC; m_instr <= NOP; m_bad <= 32'h0; m_instret <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_fetch <= 1'b1;
    end else if (m_fetch) begin
      if (imem_ack) begin
        m_instr <= imem_rdata; m_fetch <= 1'b0; m_exec <= 1'b1;
      end
    end else if (m_exec && exec_done && !stall) begin
      m_instret <= m_instret + 32'd1;
      m_exec    <= 1'b0;
      if (m_target[1]) begin
        m_trap <= 1'b1; m_bad <= m_target;
      end else begin
        m_pc <= m_target; m_fetch <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'b0, imem_req}, {31'b0, m_fetch});
    check("instr", instr, m_instr);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_exec});
    check("link", link, m_pc + 32'd4);
    check("trap", {31'b0, trap}, {31'b0, m_trap});
    check("bad_addr", bad_addr, m_bad);
    check("instret", instret, m_instret);
    if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
  end

  task automatic wait_hold(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", {31'b0, instr_valid}, 32'd1);
  endtask

  // Called at a negedge in HOLD; retires one instruction at the next rising edge.
  task automatic exec(input logic b, input logic f, input logic j, input logic jr,
                      input logic [31:0] im, input logic [31:0] r1);
    branch = b; alu_flag = f; jal = j; jalr = jr; imm = im; rs1 = r1; exec_done = 1'b1;
    @(posedge clk);
    #1;
    exec_done = 1'b0; branch = 1'b0; alu_flag = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'h0; rs1 = 32'h0;
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_bad", bad_addr, 32'd0);
    check("rst_instret", instret, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; exec_done = 1'b0; stall = 1'b0; branch = 1'b0; alu_flag = 1'b0;
    jal = 1'b0; jalr = 1'b0; imm = 32'h0; rs1 = 32'h0;
    #1 rst = 1'b1;
    #12;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch with zero-wait memory.
    for (int i = 0; i < 3; i++) begin
      wait_hold(20);
      check("seq_pc", pc, RST_PC + 32'(4 * i));
      exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    wait_hold(20);
    check("instret_3", instret, 32'd3);
    check("pc_10c", pc, 32'h0000_010C);
    check("fetch0", fetch_log[0], 32'h0000_0100);
    check("fetch1", fetch_log[1], 32'h0000_0104);
    check("fetch2", fetch_log[2], 32'h0000_0108);

    // Ack after three waiting cycles: request held four cycles.
    ack_delay = 3;
    exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    for (int k = 0; k < 20 && !instr_valid; k++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h0000_0110) n++;
    end
    check("req_cycles", 32'(n), 32'd4);
    check("instr_110", instr, 32'h0000_0110 ^ KEY);
    ack_delay = 0;

    // Branch taken / not taken around 0x200.
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00F0, 32'h0);
    wait_hold(20);
    check("pc_200", pc, 32'h0000_0200);
    exec(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    wait_hold(20);
    check("br_taken", pc, 32'h0000_01F8);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    wait_hold(20);
    exec(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    wait_hold(20);
    check("br_not_taken", pc, 32'h0000_0204);

    // Stall masks exec_done.
    exec_done = 1'b1; stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h0000_0204);
      check("stall_instret", instret, 32'd8);
    end
    exec_done = 1'b0; stall = 1'b0;

    // Sequential wrap at the top of the address space.
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FDF8, 32'h0);
    wait_hold(20);
    check("pc_top", pc, 32'hFFFF_FFFC);
    check("link_wrap", link, 32'h0000_0000);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_hold(20);
    check("pc_wrap", pc, 32'h0000_0000);
    check("trap_after_wrap", {31'b0, trap}, 32'd0);

    // JALR priority over JAL, then a misaligned JAL trap.
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    wait_hold(20);
    check("link_304", link, 32'h0000_0304);
    exec(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_1001);
    wait_hold(20);
    check("jalr_pc", pc, 32'h0000_1010);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_F2F0, 32'h0);
    wait_hold(20);
    check("pc_300", pc, 32'h0000_0300);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0);
    @(negedge clk);
    check("trap_set", {31'b0, trap}, 32'd1);
    check("trap_bad", bad_addr, 32'h0000_0306);
    check("trap_pc", pc, 32'h0000_0300);
    check("trap_instret", instret, 32'd14);
    repeat (3) @(negedge clk);
    check("trap_req", {31'b0, imem_req}, 32'd0);

    // Reset pulse while trapped, with a stray ack around release.
    @(posedge clk);
    #2 rst = 1'b1; ack_force = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 ack_force = 1'b0; ack_delay = 2;
    @(negedge clk);
    check("late_ack_ignored", instr, NOP);
    check("req_after_rst", {31'b0, imem_req}, 32'd1);

    // Reset pulse mid-request.
    @(posedge clk);
    #2 rst = 1'b1; ack_force = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 ack_force = 1'b0; ack_delay = 0;
    wait_hold(20);
    check("refetch_pc", pc, RST_PC);
    check("refetch_instr", instr, RST_PC ^ KEY);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_hold(20);
    check("refetch_next", pc, 32'h0000_0104);
    check("refetch_instret", instret, 32'd1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
